// File: rtl/cs_pair_accumulator.sv
// Resolves carry-save term pairs, sums NTERMS per pixel, then rounds, shifts and saturates to 8 bits.
// Latency 3 cycles from last-term transfer; a stalled output freezes every stage and drops in_ready.
module cs_pair_accumulator #(
  parameter int NTERMS = 4,
  parameter int SHIFT  = 4,
  parameter int ACC_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_a,
  input  logic [11:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pix,
  output logic        out_sat
);
  localparam int               CNT_W    = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NTERMS - 1);
  localparam logic [ACC_W-1:0] RND      = ACC_W'((1 << SHIFT) >> 1);

  typedef struct packed {
    logic       vld;
    logic       last;
    logic [6:0] lo;
    logic [5:0] a_hi;
    logic [5:0] b_hi;
  } s1_t;

  typedef struct packed {
    logic        vld;
    logic        last;
    logic [12:0] sum;
  } s2_t;

  s1_t              s1;
  s2_t              s2;
  logic             en;
  logic             in_fire;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] total;
  logic [ACC_W-1:0] q;
  logic [6:0]       hi_sum;
  logic             q_sat;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign in_fire  = in_valid && en;

  always_comb begin
    hi_sum   = {1'b0, s1.a_hi} + {1'b0, s1.b_hi} + 7'(s1.lo[6]);
    acc_next = acc + ACC_W'(s2.sum);
    total    = acc_next + RND;
    q        = total >> SHIFT;
    q_sat    = (q > ACC_W'(255));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (in_fire) begin
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Low half resolves in S1, its carry ripples into the high half in S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (en) begin
      s1.vld  <= in_valid;
      s1.last <= in_valid && (cnt == LAST_IDX);
      s1.lo   <= {1'b0, in_a[5:0]} + {1'b0, in_b[5:0]};
      s1.a_hi <= in_a[11:6];
      s1.b_hi <= in_b[11:6];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2 <= '0;
    end else if (en) begin
      s2.vld  <= s1.vld;
      s2.last <= s1.last;
      s2.sum  <= {hi_sum, s1.lo[5:0]};
    end
  end

  // A last term landing in the same cycle the output drains reloads it without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (en && s2.vld) begin
        acc <= s2.last ? '0 : acc_next;
      end
      if (en && s2.vld && s2.last) begin
        out_valid <= 1'b1;
        out_pix   <= q_sat ? 8'hFF : q[7:0];
        out_sat   <= q_sat;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/cs_pair_accumulator.md
# cs_pair_accumulator

Consumes the redundant carry-save pairs produced by the partial-product multiplier array and resolves them to binary. Each pair is one weighted neighbour term of a demosaicing interpolation: a 7-bit pixel times a 5-bit weight. The block runs a two-stage split carry-propagate adder and accumulates NTERMS resolved terms per output pixel. It then rounds, normalises by SHIFT and saturates, emitting one 8-bit interpolated pixel per group over a valid/ready handshake.

## Interface
- NTERMS, default 4: terms summed per output pixel; legal range 1..16.
- SHIFT, default 4: normalisation right shift; legal range 0..8.
- ACC_W, default 16: accumulator width; must be at least 13 + clog2(NTERMS) + 1.
- clk  input  1  single clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a carry-save pair is present.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  12  carry-save operand 1.
- in_b  input  12  carry-save operand 2; the true term is in_a + in_b, treated as 13-bit unsigned.
- out_valid  output  1  out_pix and out_sat are valid.
- out_ready  input  1  downstream accepts the output.
- out_pix  output  8  rounded, shifted, saturated pixel.
- out_sat  output  1  high when saturation occurred for this pixel.

## Operation
- Global advance: en = !(out_valid && !out_ready).
  - in_ready = en; this is combinational.
  - Every pipeline stage advances only when en is high.
- Input transfer occurs when in_valid && in_ready.
- Stage 1 (S1):
  - Registers lo = in_a[5:0] + in_b[5:0] as 7 bits, i.e. 6 sum bits plus a carry.
  - Registers in_a[11:6] and in_b[11:6].
  - Registers s1_valid and s1_last.
- Stage 2 (S2):
  - Computes sum13 = {in_a[11:6] + in_b[11:6] + lo[6], lo[5:0]}, i.e. 7 bits + 6 bits.
  - Registers sum13, s2_valid and s2_last.
- Term counter cnt, 0..NTERMS-1:
  - Increments on each input transfer.
  - s1_last is tagged when cnt == NTERMS-1.
  - cnt wraps to 0 after the last term.
- Stage 3, accumulate, when s2_valid and en:
  - Not last: acc <= acc + sum13.
  - Last:
    - total = acc + sum13 + R, where R = 1 << (SHIFT-1) if SHIFT > 0, else 0.
    - q = total >> SHIFT.
    - out_pix <= (q > 255) ? 255 : q[7:0].
    - out_sat <= (q > 255).
    - out_valid <= 1.
    - acc <= 0.
- Output transfer occurs when out_valid && out_ready.
  - If no new last term arrives at S3 in that cycle, out_valid <= 0.
  - If a last term arrives at S3 in that same cycle, the output registers reload and out_valid stays 1. The back-to-back result is not lost.
- Outputs hold stable while out_valid && !out_ready.
- No arithmetic wrap: ACC_W sizing guarantees NTERMS × 8191 + R fits.
- Reset values:
  - in_ready is 1 (follows from out_valid = 0).
  - out_valid, out_pix and out_sat are 0.
  - acc, cnt and all stage valid/last flags are 0.
- Reset mid-group discards every partial sum and in-flight term; the next accepted pair is term 0 of a new group.

## Timing
- Last term of a group transferred at edge E:
  - It sits in S1 after E and in S2 after E+1.
  - out_valid rises after E+2.
  - Latency is 3 cycles from transfer to result.
- Throughput is one pair per cycle and one pixel per NTERMS cycles, with no bubbles while out_ready stays high.
- Stall propagation:
  - out_valid high and out_ready low freezes S1, S2, acc and cnt, and drives in_ready low in the same cycle.
  - Release is immediate in the cycle out_ready rises.
- in_valid low creates bubbles; stage valid flags carry them, and acc is unaffected.
- NTERMS = 1: every pair produces a pixel, at a rate of one per cycle.

## Test plan
- Group sum with NTERMS=4, SHIFT=4:
  - Stimulus: pairs with resolved sums 2000, 1000, 500, 100 (in_a = sum - 37, in_b = 37).
  - Required: out_pix = 225, out_sat = 0, with out_valid 3 cycles after the fourth transfer.
- Saturation with NTERMS=4, SHIFT=4:
  - Stimulus: four terms of 127×31 = 3937.
  - Required: q = 984, so out_pix = 255 and out_sat = 1; acc reads 0 afterwards.
- Carry split with NTERMS=1, SHIFT=0:
  - in_a = 0x03F, in_b = 0x001 gives out_pix = 64.
  - in_a = 0x7FF, in_b = 0x7FF gives 4094, so out_pix = 255 and out_sat = 1.
- Backpressure with NTERMS=4:
  - Stimulus: stream 12 terms with out_ready held low for 6 cycles after the first out_valid.
  - Required: in_ready is low during the hold, exactly 3 pixels are delivered in order with correct values, and out_pix holds stable while stalled.
- Reset mid-group:
  - Stimulus: accept 2 terms of 1000, assert rst for 1 cycle, then send 4 terms of 16 with SHIFT=4.
  - Required: out_pix = 4, out_sat = 0, and no output is produced from the aborted group.
- Back-to-back output:
  - Stimulus: NTERMS=1, out_ready held high, 5 consecutive pairs with sums 16, 32, 48, 64, 80 and SHIFT=4.
  - Required: out_valid stays high for 5 cycles with out_pix = 1, 2, 3, 4, 5.
